i2c_regbank: RTL and testbench

Parametrised I2C target with an on-chip register bank. It is the successor to the single-control-register I2C core used in the coilgun top level. It oversamples SCL/SDA on the system clock, so no separate divided I2C clock is needed. It exposes P_NREGS byte registers as a flat output bus for the fire/indicator/timing logic, with pointer-addressed writes, readback and pointer auto-increment with wrap.

---
 rtl/i2c_regbank.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_regbank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regbank.sv
// I2C target with a pointer-addressed bank of byte registers.
// SCL/SDA are oversampled on the system clock. Writes go through an auto-incrementing pointer,
// reads return the bank contents, and the pointer wraps at P_NREGS.
module i2c_regbank #(
    parameter int unsigned P_NREGS   = 4,
    parameter logic [7:0]  P_RST_VAL = 8'h00
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_scl,
    input  logic                 I_sda,
    output logic                 O_sda_oe,
    input  logic [6:0]           I_myaddr,
    output logic [8*P_NREGS-1:0] O_regs,
    output logic                 O_wr_stb,
    output logic [3:0]           O_wr_idx,
    output logic                 O_busy
);

    localparam int unsigned PW = $clog2(P_NREGS);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } state_e;

    // [0],[1] synchroniser stages, [2] history flop for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [PW-1:0]       ptr_q, ptr_d, ptr_inc;
    logic [8*P_NREGS-1:0] regs_q, regs_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                slot_q, slot_d;  // ACK slot opened by its first SCL fall
    logic                rw_q, rw_d;
    logic                wr_stb_q, wr_stb_d;
    logic [3:0]          wr_idx_q, wr_idx_d;
    logic [7:0]          rx_byte, rd_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & sda_sync_q[2] & ~sda_s;
    assign stop_det  = scl_s & ~sda_sync_q[2] & sda_s;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = regs_q[{ptr_q, 3'b000} +: 8];
    assign ptr_inc = (ptr_q == PW'(P_NREGS - 1)) ? '0 : ptr_q + 1'b1;

    // Synchronise the bus pins; idle bus is high so reset the chain to 1
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], I_scl};
            sda_sync_q <= {sda_sync_q[1:0], I_sda};
        end
    end

    // Protocol state, register bank and output registers
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            regs_q    <= {P_NREGS{P_RST_VAL}};
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            slot_q    <= 1'b0;
            rw_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            slot_q    <= slot_d;
            rw_q      <= rw_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // Next-state logic; START/STOP override any SCL edge seen in the same cycle
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        slot_d    = slot_q;
        rw_d      = rw_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            slot_d    = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            slot_d  = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q != 3'd7) begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end else begin
                            bit_cnt_d = '0;
                            slot_d    = 1'b0;
                            if (state_q == StAddr) begin
                                if (rx_byte[7:1] == I_myaddr) begin
                                    state_d = StAddrAck;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StPtr) begin
                                if (32'(rx_byte) < P_NREGS) begin
                                    ptr_d   = rx_byte[PW-1:0];
                                    state_d = StPtrAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else begin
                                regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
                                wr_stb_d = 1'b1;
                                wr_idx_d = 4'(ptr_q);
                                ptr_d    = ptr_inc;
                                state_d  = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // First fall opens the ACK slot, second fall closes it
                    if (scl_fall) begin
                        if (!slot_q) begin
                            oe_d   = 1'b1;
                            slot_d = 1'b1;
                        end else begin
                            slot_d    = 1'b0;
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck && rw_q) begin
                                shift_d = rd_byte;
                                oe_d    = ~rd_byte[7];
                                state_d = StRdata;
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    // bit_cnt counts bits already clocked out; MSB was driven on entry
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            slot_d    = 1'b0;
                            state_d   = StRdataAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (scl_fall) begin
                        oe_d = ~shift_q[3'd7 - bit_cnt_q];
                    end
                end
                StRdataAck: begin
                    if (scl_fall) begin
                        if (!slot_q) begin
                            oe_d   = 1'b0;
                            slot_d = 1'b1;
                        end else begin
                            slot_d    = 1'b0;
                            bit_cnt_d = '0;
                            shift_d   = rd_byte;
                            oe_d      = ~rd_byte[7];
                            state_d   = StRdata;
                        end
                    end else if (scl_rise && slot_q) begin
                        if (sda_s) begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                            oe_d    = 1'b0;
                            slot_d  = 1'b0;
                        end else begin
                            ptr_d = ptr_inc;
                        end
                    end
                end
                StIdle, StIgnore: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign O_sda_oe = oe_q;
    assign O_regs   = regs_q;
    assign O_wr_stb = wr_stb_q;
    assign O_wr_idx = wr_idx_q;
    assign O_busy   = busy_q;

endmodule

// File: tb/tb_i2c_regbank.sv
// Directed and randomized I2C master driving i2c_regbank, checked against a byte-array model.
module tb_i2c_regbank;

    localparam int unsigned NREGS   = 4;
    localparam logic [7:0]  RST_VAL = 8'h5A;
    localparam logic [6:0]  MYADDR  = 7'h28;
    localparam int          Q       = 6;   // clocks of SCL-low setup/hold
    localparam int          H       = 12;  // clocks of SCL high

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 scl = 1'b1;
    logic                 m_sda = 1'b1;
    logic                 sda_oe;
    logic [8*NREGS-1:0]   regs;
    logic                 wr_stb;
    logic [3:0]           wr_idx;
    logic                 busy;
    logic                 sda_bus;

    int checks = 0;
    int errors = 0;

    logic [7:0] mregs [NREGS];
    int         mptr;
    logic [7:0] wq[$];
    int         exp_idx[$];
    int         got_idx[$];
    int         oe_cnt = 0;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_regbank #(
        .P_NREGS  (NREGS),
        .P_RST_VAL(RST_VAL)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .I_scl   (scl),
        .I_sda   (sda_bus),
        .O_sda_oe(sda_oe),
        .I_myaddr(MYADDR),
        .O_regs  (regs),
        .O_wr_stb(wr_stb),
        .O_wr_idx(wr_idx),
        .O_busy  (busy)
    );

    // Record every strobe cycle and every cycle the target pulls SDA
    always @(negedge clk) begin
        if (wr_stb) got_idx.push_back(int'(wr_idx));
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = RST_VAL;
        mptr = 0;
    endtask

    task automatic check_regs(input string tag);
        logic [8*NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mregs[i];
        check(tag, regs, v);
    endtask

    task automatic check_strobes(input int base);
        check("stb_count", got_idx.size() - base, exp_idx.size());
        for (int i = 0; i < exp_idx.size() && base + i < got_idx.size(); i++)
            check("stb_idx", got_idx[base + i], exp_idx[i]);
    endtask

    // START, also usable as repeated START with SCL low
    task automatic m_start();
        m_sda = 1'b1; wclk(Q);
        scl = 1'b1;   wclk(H);
        m_sda = 1'b0; wclk(H);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; wclk(Q);
        scl = 1'b1;   wclk(H);
        m_sda = 1'b1; wclk(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;  wclk(Q);
        scl = 1'b1; wclk(H);
        scl = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wclk(Q);
        scl = 1'b1;   wclk(H / 2);
        ack = sda_bus; wclk(H / 2);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wclk(Q);
            scl = 1'b1; wclk(H / 2);
            d[i] = sda_bus; wclk(H / 2);
            scl = 1'b0;
        end
        m_sda = nack; wclk(Q);
        scl = 1'b1;   wclk(H);
        scl = 1'b0;   wclk(Q);
        m_sda = 1'b1;
    endtask

    // Pointer byte p followed by the bytes queued in wq
    task automatic do_write(input int p);
        logic ack;
        int   base;
        base = got_idx.size();
        exp_idx.delete();
        m_start();
        write_byte({MYADDR, 1'b0}, ack);
        check("w_addr_ack", ack, 1'b0);
        check("w_busy", busy, 1'b1);
        write_byte(8'(p), ack);
        if (p < NREGS) begin
            check("ptr_ack", ack, 1'b0);
            mptr = p;
            foreach (wq[i]) begin
                write_byte(wq[i], ack);
                check("data_ack", ack, 1'b0);
                mregs[mptr] = wq[i];
                exp_idx.push_back(mptr);
                mptr = (mptr + 1) % NREGS;
            end
        end else begin
            check("ptr_nack", ack, 1'b1);
            foreach (wq[i]) begin
                write_byte(wq[i], ack);
                check("ign_nack", ack, 1'b1);
            end
        end
        m_stop();
        check("w_busy_stop", busy, 1'b0);
        check_regs("w_regs");
        check_strobes(base);
    endtask

    task automatic do_read(input logic setp, input int p, input int n);
        logic       ack;
        logic [7:0] d;
        int         base;
        base = got_idx.size();
        exp_idx.delete();
        m_start();
        if (setp) begin
            write_byte({MYADDR, 1'b0}, ack);
            check("r_waddr_ack", ack, 1'b0);
            write_byte(8'(p), ack);
            check("r_ptr_ack", ack, 1'b0);
            mptr = p;
            m_start();
        end
        write_byte({MYADDR, 1'b1}, ack);
        check("r_addr_ack", ack, 1'b0);
        check("r_busy", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check("rdata", d, mregs[mptr]);
            if (i < n - 1) mptr = (mptr + 1) % NREGS;
        end
        wclk(2);
        check("r_busy_nack", busy, 1'b0);
        check("r_oe_nack", sda_oe, 1'b0);
        m_stop();
        check_strobes(base);
    endtask

    task automatic do_badaddr(input logic [6:0] a);
        logic ack;
        int   base, oe0;
        base = got_idx.size();
        oe0  = oe_cnt;
        exp_idx.delete();
        m_start();
        write_byte({a, 1'b0}, ack);
        check("bad_addr_nack", ack, 1'b1);
        check("bad_busy", busy, 1'b0);
        write_byte(8'($urandom), ack);
        check("bad_data_nack", ack, 1'b1);
        m_stop();
        check("bad_no_oe", oe_cnt - oe0, 0);
        check_regs("bad_regs");
        check_strobes(base);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [6:0] a;
        int         base;

        wclk(1);
        rst_n = 1'b0;
        wclk(3);
        model_reset();
        check("rst_oe", sda_oe, 1'b0);
        check_regs("rst_regs");
        check("rst_stb", wr_stb, 1'b0);
        check("rst_idx", wr_idx, 4'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wclk(4);

        // Single write to reg1
        wq.delete(); wq.push_back(8'hA5);
        do_write(1);

        // Write across the wrap point
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(3);

        // Set pointer, repeated START, read three with wrap
        do_read(1'b1, 2, 3);

        // Wrong address then a good one
        do_badaddr(7'h2A);
        wq.delete(); wq.push_back(8'h3E);
        do_write(2);

        // Out-of-range pointer
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h01);
        do_write(7);

        // Partial byte cut off by STOP is discarded, pointer still set
        base = got_idx.size();
        exp_idx.delete();
        m_start();
        write_byte({MYADDR, 1'b0}, ack);
        write_byte(8'd2, ack);
        mptr = 2;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        m_stop();
        check_regs("partial_regs");
        check_strobes(base);
        do_read(1'b0, 0, 1);

        // Reset asserted while the target holds the ACK low
        m_start();
        write_byte({MYADDR, 1'b0}, ack);
        write_byte(8'd1, ack);
        d = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1; wclk(Q);
        scl = 1'b1;   wclk(2);
        check("oe_before_rst", sda_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("oe_async_rst", sda_oe, 1'b0);
        model_reset();
        check_regs("rst_mid_regs");
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_idx", wr_idx, 4'd0);
        wclk(3);
        rst_n = 1'b1;
        wclk(2);
        scl = 1'b0; wclk(Q);
        m_stop();
        wq.delete(); wq.push_back(8'h77);
        do_write(0);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 9);
            wq.delete();
            if (kind <= 4) begin
                n = $urandom_range(1, 3);
                repeat (n) wq.push_back(8'($urandom));
                do_write($urandom_range(0, NREGS - 1));
            end else if (kind == 5) begin
                wq.push_back(8'($urandom));
                do_write($urandom_range(NREGS, 255));
            end else if (kind <= 8) begin
                do_read(1'($urandom_range(0, 1)), $urandom_range(0, NREGS - 1),
                        $urandom_range(1, 3));
            end else begin
                a = 7'($urandom);
                while (a == MYADDR) a = 7'($urandom);
                do_badaddr(a);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
